// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind uart_rx: captures rx_data on the falling edge
// of rx_busy and presents bytes first-word-fall-through with sticky overflow.
// Ports: clk, reset (async, active-high), rx_busy, rx_data[7:0], rd_en,
//        flush, clr_overflow -> rd_data[7:0], empty, full,
//        count[ADDR_W:0], overflow.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_busy,
  input  logic [7:0]        rx_data,
  input  logic              rd_en,
  input  logic              flush,
  input  logic              clr_overflow,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              rx_busy_q;

  logic wr_evt;
  logic rd_ok;
  logic wr_ok;
  logic drop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign rd_data  = empty ? 8'h00 : mem[rd_ptr_q];

  assign wr_evt = rx_busy_q & ~rx_busy;

  always_comb begin
    rd_ok    = 1'b0;
    wr_ok    = 1'b0;
    drop     = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ok = rd_en & ~empty;
      // A read in the same cycle frees the slot a full FIFO needs.
      wr_ok = wr_evt & (~full | rd_ok);
      drop  = wr_evt & full & ~rd_ok;
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({rd_ok, wr_ok})
        2'b10:   count_d = count_q - CNT_ONE;
        2'b01:   count_d = count_q + CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    // A new drop outranks a clear in the same cycle.
    ovf_d = ovf_q;
    if (drop)              ovf_d = 1'b1;
    else if (clr_overflow) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rx_busy_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      rx_busy_q <= rx_busy;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            rx_busy;
  logic [7:0]      rx_data;
  logic            rd_en;
  logic            flush;
  logic            clr_overflow;
  logic [7:0]      rd_data;
  logic            empty;
  logic            full;
  logic [ADDR_W:0] count;
  logic            overflow;

  int n_vec = 0;
  int n_err = 0;

  byte unsigned mq[$];
  bit           m_busy;
  bit           m_ovf;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_busy      (rx_busy),
    .rx_data      (rx_data),
    .rd_en        (rd_en),
    .flush        (flush),
    .clr_overflow (clr_overflow),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic check_all(string tag);
    int n;
    n = mq.size();
    chk({tag, ".rd_data"}, rd_data, (n > 0) ? mq[0] : 8'h00);
    chk({tag, ".count"}, count, n);
    chk({tag, ".empty"}, empty, n == 0);
    chk({tag, ".full"}, full, n == DEPTH);
    chk({tag, ".ovf"}, overflow, m_ovf);
  endtask

  // Apply one cycle of inputs, advance the model, check after the edge.
  task automatic cycle(bit b, byte unsigned d, bit r, bit f, bit c,
                       string tag);
    bit wr, rdok, drop;
    rx_busy = b; rx_data = d; rd_en = r;
    flush = f; clr_overflow = c;
    @(posedge clk);
    wr   = m_busy && !b;
    drop = 1'b0;
    if (f) begin
      mq.delete();
    end else begin
      rdok = r && (mq.size() > 0);
      drop = wr && (mq.size() == DEPTH) && !rdok;
      if (rdok) void'(mq.pop_front());
      if (wr && !drop) mq.push_back(d);
    end
    if (drop)   m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    m_busy = b;
    #1;
    check_all(tag);
  endtask

  task automatic frame(byte unsigned d, bit r, bit f, string tag);
    cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, tag);
    cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, tag);
    cycle(1'b0, d, r, f, 1'b0, tag);
  endtask

  task automatic pop(int n, string tag);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, tag);
  endtask

  initial begin
    bit b;
    int rp;
    reset = 1'b1; rx_busy = 1'b0; rx_data = 8'h00;
    rd_en = 1'b0; flush = 1'b0; clr_overflow = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    reset = 1'b0;

    // 1: reset mid-frame, no spurious write on release
    cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, "t1a");
    reset = 1'b1;
    model_reset();
    #1;
    check_all("t1_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b0, 8'h33, 1'b0, 1'b0, 1'b0, "t1_nowr");
    chk("t1_cnt0", count, 0);
    frame(8'hA5, 1'b0, 1'b0, "t1_frm");
    chk("t1_cnt1", count, 1);
    chk("t1_a5", rd_data, 8'hA5);
    pop(1, "t1_pop");

    // 2: order and pointer wrap with interleaved pops
    for (int i = 0; i < 20; i++)
      frame(8'(i), (i % 3) == 2, 1'b0, "t2");
    pop(DEPTH + 2, "t2_drain");
    chk("t2_empty", empty, 1);

    // 3: overflow and clear
    for (int i = 0; i < DEPTH; i++)
      frame(8'(8'h40 + i), 1'b0, 1'b0, "t3_fill");
    chk("t3_full", full, 1);
    frame(8'h77, 1'b0, 1'b0, "t3_drop");
    chk("t3_ovf", overflow, 1);
    chk("t3_head", rd_data, 8'h40);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "t3_clr");
    chk("t3_ovf0", overflow, 0);

    // 4: simultaneous write and read when full, then when empty
    frame(8'h3C, 1'b1, 1'b0, "t4_full");
    chk("t4_cnt16", count, DEPTH);
    chk("t4_ovf0", overflow, 0);
    pop(DEPTH - 1, "t4_drain");
    chk("t4_last", rd_data, 8'h3C);
    pop(1, "t4_drain");
    frame(8'h5A, 1'b1, 1'b0, "t4_empty");
    chk("t4_cnt1", count, 1);
    chk("t4_5a", rd_data, 8'h5A);
    pop(1, "t4_pop");

    // 5: flush with concurrent write and overflow set
    for (int i = 0; i < DEPTH + 1; i++)
      frame(8'(8'h80 + i), 1'b0, 1'b0, "t5_fill");
    pop(DEPTH - 5, "t5_pop");
    chk("t5_cnt5", count, 5);
    frame(8'hEE, 1'b0, 1'b1, "t5_flush");
    chk("t5_cnt0", count, 0);
    chk("t5_rd0", rd_data, 8'h00);
    chk("t5_ovf", overflow, 1);
    frame(8'h11, 1'b0, 1'b0, "t5_next");
    chk("t5_11", rd_data, 8'h11);
    pop(1, "t5_pop2");

    // 6: underflow is ignored
    pop(4, "t6");
    chk("t6_cnt", count, 0);
    chk("t6_empty", empty, 1);

    // random traffic with phased read pressure
    b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rp = (i / 250) % 3;
      if ($urandom_range(0, 2) == 0) b = ~b;
      cycle(b, 8'($urandom),
            $urandom_range(0, 9) < (rp * 4 + 1),
            $urandom_range(0, 149) == 0,
            $urandom_range(0, 29) == 0, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
